// File: rtl/data_mem_requester.sv
// Load/store master for the banked data memory manager.
// Splits halfwords into two byte beats and returns sized, extended loads.
module data_mem_requester #(
  parameter int RD_LAT = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] address_o,
  output logic [31:0] data_o,
  output logic        wren_o,
  output logic [31:0] byte_mode_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [7:0]  whi_q, whi_d;
  logic        beat_q, beat_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  lo_q, lo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] address_q, address_d;
  logic [31:0] data_q, data_d;
  logic        bad;

  function automatic logic [31:0] ext(
    input logic [15:0] v,
    input logic        half,
    input logic        sg
  );
    logic [31:0] r;
    if (half)
      r = sg ? {{16{v[15]}}, v} : {16'b0, v};
    else
      r = sg ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
    return r;
  endfunction

  // Misaligned or illegal-size request detection at accept
  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      (size_i == SZ_B): bad = 1'b0;
      (size_i == SZ_H): bad = addr_i[0];
      (size_i == SZ_W): bad = |addr_i[1:0];
      default:          bad = 1'b1;
    endcase
  end

  // Next-state, beat sequencing and load assembly
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    size_d    = size_q;
    signed_d  = signed_q;
    whi_d     = whi_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    address_d = address_q;
    data_d    = data_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (req_i) begin
          we_d     = we_i;
          size_d   = size_i;
          signed_d = signed_i;
          whi_d    = wdata_i[15:8];
          beat_d   = 1'b0;
          err_d    = bad;
          if (bad) begin
            state_d = S_RESP;
          end else begin
            state_d   = S_ISSUE;
            address_d = addr_i;
            data_d    = (size_i == SZ_W) ? wdata_i
                                         : {24'b0, wdata_i[7:0]};
          end
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          if (size_q == SZ_H && !beat_q) begin
            beat_d    = 1'b1;
            address_d = {address_q[31:1], 1'b1};
            data_d    = {24'b0, whi_q};
          end else begin
            state_d = S_RESP;
          end
        end else begin
          state_d = S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          if (size_q == SZ_H && !beat_q) begin
            state_d   = S_ISSUE;
            beat_d    = 1'b1;
            lo_d      = mem_data_i[7:0];
            address_d = {address_q[31:1], 1'b1};
          end else begin
            state_d = S_RESP;
            unique case (1'b1)
              (size_q == SZ_W):
                rdata_d = mem_data_i;
              (size_q == SZ_H):
                rdata_d = ext({mem_data_i[7:0], lo_q},
                              1'b1, signed_q);
              default:
                rdata_d = ext({8'b0, mem_data_i[7:0]},
                              1'b0, signed_q);
            endcase
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'b00;
      signed_q  <= 1'b0;
      whi_q     <= 8'h00;
      beat_q    <= 1'b0;
      cnt_q     <= 2'd0;
      lo_q      <= 8'h00;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      address_q <= 32'h0;
      data_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      whi_q     <= whi_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      lo_q      <= lo_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      address_q <= address_d;
      data_q    <= data_d;
    end
  end

  // Outputs decoded from state and registered fields only
  always_comb begin
    busy_o      = (state_q == S_ISSUE) || (state_q == S_WAIT);
    done_o      = (state_q == S_RESP);
    err_o       = (state_q == S_RESP) && err_q;
    wren_o      = (state_q == S_ISSUE) && we_q;
    byte_mode_o = {31'b0, busy_o && (size_q != SZ_W)};
    rdata_o     = rdata_q;
    address_o   = address_q;
    data_o      = data_q;
  end

endmodule
